// File: rtl/sdram_port_arbiter.sv
// Shares one SDRAM controller command port between video (port 0), CPU (port 1) and
// upload (port 2): video has priority, 1/2 round-robin, and a starvation guard caps video.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W     = 24,
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned BE_W       = 2,
  parameter int unsigned STARVE_MAX = 8
) (
  input  logic                clk_sys,
  input  logic                reset_n,
  input  logic [2:0]          p_req,
  input  logic [2:0]          p_we,
  input  logic [3*ADDR_W-1:0] p_addr,
  input  logic [3*DATA_W-1:0] p_wdata,
  input  logic [3*BE_W-1:0]   p_be,
  output logic [2:0]          p_ack,
  output logic [DATA_W-1:0]   p_rdata,
  output logic                ctl_req,
  output logic                ctl_we,
  output logic [ADDR_W-1:0]   ctl_addr,
  output logic [DATA_W-1:0]   ctl_wdata,
  output logic [BE_W-1:0]     ctl_be,
  input  logic                ctl_ready,
  input  logic                ctl_done,
  input  logic [DATA_W-1:0]   ctl_rdata,
  output logic                busy
);

  localparam logic [7:0] StarveMax = 8'(STARVE_MAX);

  typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

  state_e              state_q, state_d;
  logic [1:0]          win_q, win_d;
  logic                rr_q, rr_d;  // 0: port 1 preferred, 1: port 2 preferred
  logic [7:0]          starve_q, starve_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [2:0]          ack_q, ack_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic [1:0]          grant;
  logic                sel_we;
  logic [ADDR_W-1:0]   sel_addr;
  logic [DATA_W-1:0]   sel_wdata;
  logic [BE_W-1:0]     sel_be;

  always_comb begin
    grant = 2'd0;
    if (p_req[0] && (starve_q < StarveMax)) begin
      grant = 2'd0;
    end else if (p_req[1] && p_req[2]) begin
      grant = rr_q ? 2'd2 : 2'd1;
    end else if (p_req[1]) begin
      grant = 2'd1;
    end else if (p_req[2]) begin
      grant = 2'd2;
    end
  end

  always_comb begin
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < 3; i++) begin
      if (grant == 2'(i)) begin
        sel_we    = p_we[i];
        sel_addr  = p_addr[i*ADDR_W +: ADDR_W];
        sel_wdata = p_wdata[i*DATA_W +: DATA_W];
        sel_be    = p_be[i*BE_W +: BE_W];
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    win_d    = win_q;
    rr_d     = rr_q;
    starve_d = starve_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    be_d     = be_q;
    ack_d    = '0;
    rdata_d  = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (p_req[2:1] == 2'b00) begin
          starve_d = '0;
        end
        if (p_req != 3'b000) begin
          state_d = StIssue;
          win_d   = grant;
          we_d    = sel_we;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          be_d    = sel_be;
          if (grant == 2'd0) begin
            if ((p_req[2:1] != 2'b00) && (starve_q < StarveMax)) begin
              starve_d = starve_q + 8'd1;
            end
          end else begin
            starve_d = '0;
            rr_d     = (grant == 2'd1);
          end
        end
      end
      StIssue: begin
        // A ctl_done seen here has no outstanding command behind it and is dropped.
        if (ctl_ready) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (ctl_done) begin
          rdata_d = ctl_rdata;
          ack_d   = 3'b001 << win_q;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= StIdle;
      win_q    <= 2'd0;
      rr_q     <= 1'b0;
      starve_q <= '0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      ack_q    <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      win_q    <= win_d;
      rr_q     <= rr_d;
      starve_q <= starve_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      ack_q    <= ack_d;
      rdata_q  <= rdata_d;
    end
  end

  assign ctl_req   = (state_q == StIssue);
  assign busy      = (state_q != StIdle);
  assign ctl_we    = we_q;
  assign ctl_addr  = addr_q;
  assign ctl_wdata = wdata_q;
  assign ctl_be    = be_q;
  assign p_ack     = ack_q;
  assign p_rdata   = rdata_q;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter: a small controller model plus grant/ack scoreboards.
module tb_sdram_port_arbiter;

  localparam int unsigned ADDR_W = 24;
  localparam int unsigned DATA_W = 16;
  localparam int unsigned BE_W   = 2;

  logic                clk_sys = 1'b0;
  logic                reset_n = 1'b0;
  logic [2:0]          p_req = '0;
  logic [2:0]          we_v = '0;
  logic [ADDR_W-1:0]   addr_v [3];
  logic [DATA_W-1:0]   wdata_v [3];
  logic [BE_W-1:0]     be_v [3];
  logic [3*ADDR_W-1:0] p_addr;
  logic [3*DATA_W-1:0] p_wdata;
  logic [3*BE_W-1:0]   p_be;
  logic [2:0]          p_ack;
  logic [DATA_W-1:0]   p_rdata;
  logic                ctl_req, ctl_we, busy;
  logic [ADDR_W-1:0]   ctl_addr;
  logic [DATA_W-1:0]   ctl_wdata;
  logic [BE_W-1:0]     ctl_be;
  logic                ctl_ready = 1'b1;
  logic                ctl_done = 1'b0;
  logic [DATA_W-1:0]   ctl_rdata = '0;

  assign p_addr  = {addr_v[2], addr_v[1], addr_v[0]};
  assign p_wdata = {wdata_v[2], wdata_v[1], wdata_v[0]};
  assign p_be    = {be_v[2], be_v[1], be_v[0]};

  sdram_port_arbiter dut (
    .clk_sys   (clk_sys),
    .reset_n   (reset_n),
    .p_req     (p_req),
    .p_we      (we_v),
    .p_addr    (p_addr),
    .p_wdata   (p_wdata),
    .p_be      (p_be),
    .p_ack     (p_ack),
    .p_rdata   (p_rdata),
    .ctl_req   (ctl_req),
    .ctl_we    (ctl_we),
    .ctl_addr  (ctl_addr),
    .ctl_wdata (ctl_wdata),
    .ctl_be    (ctl_be),
    .ctl_ready (ctl_ready),
    .ctl_done  (ctl_done),
    .ctl_rdata (ctl_rdata),
    .busy      (busy)
  );

  always #5 clk_sys = ~clk_sys;

  typedef struct packed {
    logic [1:0]        port;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [BE_W-1:0]   be;
  } exp_t;

  exp_t              grant_q[$];
  exp_t              ack_q[$];
  logic [2:0]        cont = '0;  // ports that keep requesting after their ack
  int                checks = 0;
  int                fails = 0;
  int                cyc = 0;
  int                lat = 3;
  int                done_cnt = 0;
  int                last_ack_cyc = 0;
  int                t0 = 0;
  logic [DATA_W-1:0] pend_rdata = '0;
  logic [DATA_W-1:0] last_rd = '0;

  function automatic logic [DATA_W-1:0] rd_of(input logic [ADDR_W-1:0] a);
    return a[15:0] ^ 16'hACDB;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int port);
    exp_t e;
    e.port  = 2'(port);
    e.we    = we_v[port];
    e.addr  = addr_v[port];
    e.wdata = wdata_v[port];
    e.be    = be_v[port];
    grant_q.push_back(e);
    ack_q.push_back(e);
  endtask

  // Finishes the current cycle (controller acceptance), then samples the next one at negedge.
  task automatic cycle();
    exp_t e;
    if (reset_n && ctl_req && ctl_ready && grant_q.size() != 0) begin
      void'(grant_q.pop_front());
      done_cnt   = lat;
      pend_rdata = rd_of(ctl_addr);
    end
    @(posedge clk_sys);
    @(negedge clk_sys);
    cyc++;
    ctl_done = 1'b0;
    if (done_cnt > 0) begin
      done_cnt--;
      if (done_cnt == 0) begin
        ctl_done  = 1'b1;
        ctl_rdata = pend_rdata;
      end
    end
    if (p_ack != 3'b000) begin
      if (ack_q.size() == 0) begin
        check("stray_ack", 64'(p_ack), 64'd0);
      end else begin
        e = ack_q.pop_front();
        check("ack_port", 64'(p_ack), 64'(3'b001 << e.port));
        check("ack_rdata", 64'(p_rdata), 64'(rd_of(e.addr)));
        last_rd      = rd_of(e.addr);
        last_ack_cyc = cyc;
        if (!cont[e.port]) p_req[e.port] = 1'b0;
        if (grant_q.size() == 0) p_req = '0;
      end
    end
    if (ctl_req) begin
      if (grant_q.size() == 0) begin
        check("stray_req", 64'(ctl_req), 64'd0);
      end else begin
        e = grant_q[0];
        check("ctl_we", 64'(ctl_we), 64'(e.we));
        check("ctl_addr", 64'(ctl_addr), 64'(e.addr));
        check("ctl_wdata", 64'(ctl_wdata), 64'(e.wdata));
        check("ctl_be", 64'(ctl_be), 64'(e.be));
      end
    end
  endtask

  task automatic drain(input int max_cycles);
    int n;
    n = 0;
    while ((grant_q.size() != 0 || ack_q.size() != 0) && n < max_cycles) begin
      cycle();
      n++;
    end
    check("drain_timeout", 64'(grant_q.size() + ack_q.size()), 64'd0);
    repeat (2) cycle();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      addr_v[i]  = 24'h0A0000 + 24'(i * 24'h111);
      wdata_v[i] = 16'h1000 + 16'(i * 16'h0101);
      be_v[i]    = 2'(i + 1);
    end

    // Reset state
    repeat (2) cycle();
    check("rst_ctl_req", 64'(ctl_req), 64'd0);
    check("rst_p_ack", 64'(p_ack), 64'd0);
    check("rst_p_rdata", 64'(p_rdata), 64'd0);
    check("rst_ctl_fields", 64'({ctl_we, ctl_addr, ctl_wdata, ctl_be}), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    reset_n = 1'b1;
    cycle();

    // Single CPU read, L=3 -> ack 5 cycles after the request is sampled
    addr_v[1] = 24'h001234;
    we_v[1]   = 1'b0;
    lat       = 3;
    push(1);
    p_req = 3'b010;
    t0    = cyc;
    cycle();
    check("req_rise", 64'(ctl_req), 64'd1);
    cycle();
    check("busy_wait", 64'(busy), 64'd1);
    drain(50);
    check("read_latency", 64'(last_ack_cyc - t0), 64'd5);
    check("read_rdata", 64'(p_rdata), 64'h0000BEEF);

    // Stray ctl_done in IDLE
    ctl_done  = 1'b1;
    ctl_rdata = 16'hDEAD;
    cycle();
    cycle();
    check("stray_done_ack", 64'(p_ack), 64'd0);
    check("rdata_hold", 64'(p_rdata), 64'(last_rd));

    // Upload write alone, then CPU/upload round-robin with writes
    we_v = 3'b110;
    lat  = 2;
    push(2);
    p_req = 3'b100;
    drain(50);
    cont = 3'b110;
    for (int i = 0; i < 4; i++) push((i % 2 == 0) ? 1 : 2);
    p_req = 3'b110;
    drain(100);

    // Starvation guard: 8 video grants, then one of 1/2, alternating
    cont = 3'b111;
    lat  = 1;
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 8; i++) push(0);
      push((r == 0) ? 1 : 2);
    end
    p_req = 3'b111;
    drain(300);

    // Backpressure: fields stable while ctl_ready is low, late video request waits
    cont      = '0;
    ctl_ready = 1'b0;
    lat       = 2;
    push(1);
    p_req = 3'b010;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_ctl_req", 64'(ctl_req), 64'd1);
      if (i == 3) begin
        push(0);
        p_req[0] = 1'b1;
      end
    end
    ctl_ready = 1'b1;
    ctl_done  = 1'b1;  // coincides with acceptance in ISSUE
    ctl_rdata = 16'hDEAD;
    drain(100);

    // Port 1 withdraws its request after being latched
    push(1);
    p_req = 3'b010;
    cycle();
    p_req = 3'b000;
    drain(50);

    // Reset in WAIT
    lat = 6;
    push(0);
    p_req = 3'b001;
    cycle();
    cycle();
    check("pre_rst_busy", 64'(busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("rst_wait_busy", 64'(busy), 64'd0);
    check("rst_wait_req", 64'(ctl_req), 64'd0);
    check("rst_wait_ack", 64'(p_ack), 64'd0);
    grant_q.delete();
    ack_q.delete();
    done_cnt = 0;
    ctl_done = 1'b0;
    p_req    = '0;
    repeat (2) cycle();
    reset_n = 1'b1;
    lat     = 2;
    for (int i = 0; i < 8; i++) cycle();
    check("post_rst_ack", 64'(p_ack), 64'd0);
    push(1);
    push(2);
    p_req = 3'b110;
    drain(100);
    push(2);
    p_req = 3'b100;
    drain(50);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
